// File: rtl/olimp_dot_seq.sv
// olimp_dot_seq: PCPI sequencer for the OLIMP vector MAC datapath.
// Decodes custom-0 DOT/DOTACC, streams N data/coef addresses one per cycle,
// waits out the datapath pipeline and returns sum(acc0+acc1) in pcpi_rd.
// Optional build macro OLIMP_DOT_SAT_EN: signed saturating accumulation plus a
// sticky 'sat' output port.
module olimp_dot_seq #(
  parameter int unsigned PIPE_LAT    = 2,
  parameter int unsigned CNT_W       = 12,
  parameter int unsigned DATA_STRIDE = 8,
  parameter int unsigned COEF_STRIDE = 16
) (
  input  logic        clk_cpu,
  input  logic        resetn,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic        dp_sel,
  output logic [16:0] dp_data_addr,
  output logic [14:0] dp_coef_addr,
  input  logic [31:0] dp_acc0,
  input  logic [31:0] dp_acc1,
  output logic        busy
`ifdef OLIMP_DOT_SAT_EN
  ,
  output logic        sat
`endif
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  localparam logic [PIPE_LAT-1:0] VldOne = 1;

  state_e              state_q, state_d;
  logic [16:0]         data_addr_q, data_addr_d;
  logic [14:0]         coef_addr_q, coef_addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PIPE_LAT-1:0] vld_q, vld_d;
  logic [31:0]         sum_q, sum_d;
  logic                sat_q, sat_d;
  logic                ready_q;

  logic                match, is_acc, accept;
  logic [CNT_W-1:0]    n_req;
  logic [31:0]         step_sum;
  logic                step_clip;

  assign is_acc = (pcpi_insn[14:12] == 3'b001);
  assign match  = (pcpi_insn[6:0] == 7'b0001011) && (pcpi_insn[31:25] == 7'd0) &&
                  ((pcpi_insn[14:12] == 3'b000) || is_acc);
  // ready_q blocks re-accepting the same instruction the cycle after completion
  assign accept = pcpi_valid && match && !ready_q;
  assign n_req  = pcpi_rs2[20 +: CNT_W];

`ifdef OLIMP_DOT_SAT_EN
  logic signed [33:0] wide_sum;

  // Saturating accumulate step computed at 34 bits
  always_comb begin
    wide_sum  = $signed({{2{dp_acc0[31]}}, dp_acc0}) + $signed({{2{dp_acc1[31]}}, dp_acc1}) +
                $signed({{2{sum_q[31]}}, sum_q});
    step_sum  = wide_sum[31:0];
    step_clip = 1'b0;
    if (wide_sum > 34'sh0_7FFF_FFFF) begin
      step_sum  = 32'h7FFF_FFFF;
      step_clip = 1'b1;
    end else if (wide_sum < 34'sh3_8000_0000) begin
      step_sum  = 32'h8000_0000;
      step_clip = 1'b1;
    end
  end

  assign sat = sat_q;
`else
  assign step_sum  = dp_acc0 + dp_acc1 + sum_q;
  assign step_clip = 1'b0;
`endif

  // Next-state logic: sequencing, address stepping and accumulation
  always_comb begin
    state_d     = state_q;
    data_addr_d = data_addr_q;
    coef_addr_d = coef_addr_q;
    cnt_d       = cnt_q;
    vld_d       = vld_q << 1;
    sum_d       = sum_q;
    sat_d       = sat_q;

    if (vld_q[PIPE_LAT-1]) begin
      sum_d = step_sum;
      sat_d = sat_q | step_clip;
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          data_addr_d = pcpi_rs1[16:0];
          coef_addr_d = pcpi_rs2[14:0];
          cnt_d       = n_req;
          if (!is_acc) begin
            sum_d = 32'd0;
            sat_d = 1'b0;
          end
          state_d = (n_req == '0) ? StDone : StIssue;
        end
      end
      StIssue: begin
        vld_d       = vld_d | VldOne;
        data_addr_d = data_addr_q + 17'(DATA_STRIDE);
        coef_addr_d = coef_addr_q + 15'(COEF_STRIDE);
        cnt_d       = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = StDrain;
      end
      StDrain: begin
        if (vld_d == '0) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk_cpu) begin
    if (!resetn) begin
      state_q     <= StIdle;
      data_addr_q <= '0;
      coef_addr_q <= '0;
      cnt_q       <= '0;
      vld_q       <= '0;
      sum_q       <= '0;
      sat_q       <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_addr_q <= data_addr_d;
      coef_addr_q <= coef_addr_d;
      cnt_q       <= cnt_d;
      vld_q       <= vld_d;
      sum_q       <= sum_d;
      sat_q       <= sat_d;
      ready_q     <= (state_q == StDone);
    end
  end

  // Outputs decoded from state
  always_comb begin
    pcpi_wait    = (state_q == StIssue) || (state_q == StDrain);
    dp_sel       = pcpi_wait;
    pcpi_ready   = (state_q == StDone);
    pcpi_wr      = pcpi_ready;
    pcpi_rd      = pcpi_ready ? sum_q : 32'd0;
    busy         = (state_q != StIdle);
    dp_data_addr = data_addr_q;
    dp_coef_addr = coef_addr_q;
  end

endmodule

// File: tb/tb_olimp_dot_seq.sv
// Self-checking bench for olimp_dot_seq: vector table plus reset/unmatched sequences.
module tb_olimp_dot_seq;

  localparam int PipeLat = 2;

  logic        clk_cpu = 1'b0;
  logic        resetn;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic        pcpi_wr, pcpi_wait, pcpi_ready, dp_sel, busy;
  logic [31:0] pcpi_rd;
  logic [16:0] dp_data_addr;
  logic [14:0] dp_coef_addr;
  logic [31:0] dp_acc0, dp_acc1;
`ifdef OLIMP_DOT_SAT_EN
  logic        sat;
`endif

  always #5 clk_cpu = ~clk_cpu;

  olimp_dot_seq #(
    .PIPE_LAT   (PipeLat),
    .CNT_W      (12),
    .DATA_STRIDE(8),
    .COEF_STRIDE(16)
  ) dut (
    .clk_cpu     (clk_cpu),
    .resetn      (resetn),
    .pcpi_valid  (pcpi_valid),
    .pcpi_insn   (pcpi_insn),
    .pcpi_rs1    (pcpi_rs1),
    .pcpi_rs2    (pcpi_rs2),
    .pcpi_wr     (pcpi_wr),
    .pcpi_rd     (pcpi_rd),
    .pcpi_wait   (pcpi_wait),
    .pcpi_ready  (pcpi_ready),
    .dp_sel      (dp_sel),
    .dp_data_addr(dp_data_addr),
    .dp_coef_addr(dp_coef_addr),
    .dp_acc0     (dp_acc0),
    .dp_acc1     (dp_acc1),
    .busy        (busy)
`ifdef OLIMP_DOT_SAT_EN
    ,
    .sat         (sat)
`endif
  );

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [16:0] rs1;
    logic [14:0] caddr;
    int          n;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] exp_rd;
  } vec_t;

  int tests  = 0;
  int failed = 0;

  logic [31:0] rd_q[$];
  int          lat_q[$];
  logic [16:0] da_q[$];
  logic [14:0] ca_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_cpu);
    #1;
  endtask

  function automatic logic [31:0] mk_insn(input logic [2:0] f3);
    return {7'b0, 10'b0, f3, 5'b0, 7'b0001011};
  endfunction

  task automatic do_op(input vec_t v);
    int          cyc;
    bit          done_seen;
    bit          sel_seen;
    logic [31:0] e_rd;
    int          e_lat;
    dp_acc0 = v.a0;
    dp_acc1 = v.a1;
    rd_q.push_back(v.exp_rd);
    lat_q.push_back((v.n == 0) ? 1 : v.n + PipeLat + 1);
    for (int i = 0; i < v.n; i++) begin
      da_q.push_back(v.rs1 + 17'(i * 8));
      ca_q.push_back(v.caddr + 15'(i * 16));
    end
    pcpi_insn  = mk_insn(v.f3);
    pcpi_rs1   = {15'b0, v.rs1};
    pcpi_rs2   = {12'(v.n), 5'b0, v.caddr};
    pcpi_valid = 1'b1;
    cyc = 0;
    done_seen = 1'b0;
    sel_seen = 1'b0;
    while (!done_seen && cyc < 400) begin
      tick();
      cyc++;
      if (dp_sel) sel_seen = 1'b1;
      if (dp_sel && da_q.size() > 0) begin
        check({v.name, "_daddr"}, 32'(dp_data_addr), 32'(da_q.pop_front()));
        check({v.name, "_caddr"}, 32'(dp_coef_addr), 32'(ca_q.pop_front()));
      end
      if (pcpi_ready) begin
        done_seen = 1'b1;
        if (rd_q.size() == 0) begin
          check({v.name, "_unexpected_ready"}, 32'(rd_q.size()), 32'd1);
        end else begin
          e_rd  = rd_q.pop_front();
          e_lat = lat_q.pop_front();
          check({v.name, "_rd"}, pcpi_rd, e_rd);
          check({v.name, "_latency"}, 32'(cyc), 32'(e_lat));
          check({v.name, "_wr"}, 32'(pcpi_wr), 32'd1);
        end
      end
    end
    if (!done_seen) begin
      check({v.name, "_timeout"}, 32'(pcpi_ready), 32'd1);
      rd_q.delete();
      lat_q.delete();
    end
    check({v.name, "_sel_seen"}, 32'(sel_seen), 32'(v.n != 0));
    check({v.name, "_addr_left"}, 32'(da_q.size()), 32'd0);
    da_q.delete();
    ca_q.delete();
    // Valid stays high the cycle after ready; it must not be re-executed
    tick();
    pcpi_valid = 1'b0;
    tick();
    check({v.name, "_no_reexec"}, 32'(busy), 32'd0);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_ctrl"}, {27'b0, pcpi_wr, pcpi_wait, pcpi_ready, dp_sel, busy}, 32'd0);
    check({name, "_rd"}, pcpi_rd, 32'd0);
    check({name, "_addr"}, {dp_data_addr, dp_coef_addr}, 32'd0);
`ifdef OLIMP_DOT_SAT_EN
    check({name, "_sat"}, 32'(sat), 32'd0);
`endif
  endtask

  vec_t vecs[$];

  initial begin
    int bad;
    vec_t v;
    logic [31:0] wrap_exp;
`ifdef OLIMP_DOT_SAT_EN
    wrap_exp = 32'h7FFF_FFFF;
`else
    wrap_exp = 32'h8000_0000;
`endif
    vecs.push_back('{"dot3",      3'b000, 17'h00100, 15'h0040, 3, 32'd5, 32'd5, 32'd30});
    vecs.push_back('{"dot1",      3'b000, 17'h00200, 15'h0100, 1, 32'd3, 32'd4, 32'd7});
    vecs.push_back('{"dotacc1",   3'b001, 17'h00300, 15'h0200, 1, 32'd3, 32'd4, 32'd14});
    vecs.push_back('{"dotacc0",   3'b001, 17'h00000, 15'h0000, 0, 32'd9, 32'd9, 32'd14});
    vecs.push_back('{"dot0",      3'b000, 17'h00000, 15'h0000, 0, 32'd9, 32'd9, 32'd0});
    vecs.push_back('{"dot_neg",   3'b000, 17'h00010, 15'h0020, 4, 32'hFFFF_FFFF,
                     32'hFFFF_FFFE, 32'hFFFF_FFF4});
    vecs.push_back('{"addr_wrap", 3'b000, 17'h1FFF8, 15'h7FF0, 2, 32'd1, 32'd2, 32'd6});
    vecs.push_back('{"dotacc2",   3'b001, 17'h00010, 15'h0000, 2, 32'd10, 32'd20, 32'd66});
    vecs.push_back('{"sum_wrap",  3'b000, 17'h00000, 15'h0000, 1, 32'h7FFF_FFFF, 32'd1,
                     wrap_exp});

    resetn     = 1'b0;
    pcpi_valid = 1'b0;
    pcpi_insn  = '0;
    pcpi_rs1   = '0;
    pcpi_rs2   = '0;
    dp_acc0    = '0;
    dp_acc1    = '0;
    tick();
    tick();
    check_outputs_zero("reset");
    resetn = 1'b1;
    tick();

    foreach (vecs[i]) do_op(vecs[i]);

`ifdef OLIMP_DOT_SAT_EN
    check("sat_set", 32'(sat), 32'd1);
    v = '{"sat_clear", 3'b000, 17'h0, 15'h0, 1, 32'd1, 32'd1, 32'd2};
    do_op(v);
    check("sat_cleared", 32'(sat), 32'd0);
`endif

    // Unmatched funct3 held for 20 cycles: never claimed
    pcpi_insn  = mk_insn(3'b010);
    pcpi_rs2   = {12'd1, 20'd0};
    pcpi_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pcpi_wait || pcpi_ready || busy) bad++;
    end
    check("unmatched", 32'(bad), 32'd0);
    pcpi_valid = 1'b0;
    tick();

    // Reset in the middle of a long operation aborts it
    dp_acc0    = 32'd5;
    dp_acc1    = 32'd5;
    pcpi_insn  = mk_insn(3'b000);
    pcpi_rs1   = 32'h0000_0400;
    pcpi_rs2   = {12'd100, 5'b0, 15'h0100};
    pcpi_valid = 1'b1;
    tick();
    tick();
    tick();
    check("midop_busy", {30'b0, busy, dp_sel}, 32'd3);
    resetn     = 1'b0;
    pcpi_valid = 1'b0;
    tick();
    check_outputs_zero("midop_reset");
    resetn = 1'b1;
    tick();
    check("post_reset_no_ready", 32'(pcpi_ready), 32'd0);
    v = '{"after_reset", 3'b000, 17'h00040, 15'h0080, 1, 32'd5, 32'd5, 32'd10};
    do_op(v);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
